// File: rtl/fnd_mux_scanner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fnd_mux_scanner: channel select, double-dabble BCD, multiplexed FND.   |
// | FND_LZB_EN enables leading-zero blanking.   Rev 1.0                    |
// +------------------------------------------------------------------------+
module fnd_mux_scanner #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 14,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int AUTO_DIV   = 200000000,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                     sysclk,
    input  logic                     i_rst_n,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [CH_W-1:0]          i_ch_sel,
    input  logic                     i_auto,
    output logic [NUM_DIGITS-1:0]    o_fndSelect,
    output logic [7:0]               o_fndFont,
    output logic [CH_W-1:0]          o_ch_active,
    output logic                     o_ovf
);

    function automatic int dec_digits(input int w);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 10) begin
                v = v / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] seg_font(input logic [3:0] d);
        logic [7:0] f;
        case (d)
            4'd0:    f = 8'hC0;
            4'd1:    f = 8'hF9;
            4'd2:    f = 8'hA4;
            4'd3:    f = 8'hB0;
            4'd4:    f = 8'h99;
            4'd5:    f = 8'h92;
            4'd6:    f = 8'h82;
            4'd7:    f = 8'hF8;
            4'd8:    f = 8'h80;
            4'd9:    f = 8'h90;
            default: f = 8'hFF;
        endcase
        return f;
    endfunction

    localparam int NIB    = dec_digits(DATA_W);
    localparam int BCD_W  = 4 * NIB;
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int PAD_W  = (NIB > NUM_DIGITS) ? BCD_W : DISP_W;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int AUTO_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SH_W   = $clog2(DATA_W + 1);
    localparam logic [CH_W:0] NUM_CH_C = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [DIG_W-1:0]    digit_idx, digit_idx_nxt;
    logic                scan_tc, frame_wrap, start;
    logic [AUTO_W-1:0]   auto_cnt;
    logic [CH_W-1:0]     rot_ch, sel_ch, conv_ch;
    logic [DATA_W-1:0]   bin;
    logic [BCD_W-1:0]    bcd, bcd_adj;
    logic [SH_W-1:0]     sh_cnt;
    logic [PAD_W-1:0]    bcd_pad;
    logic                conv_ovf, commit;
    logic [DISP_W-1:0]   disp, disp_nxt;
    logic                valid, valid_nxt, ovf_nxt, blank;
    logic [NUM_DIGITS-1:0] sel_nxt, digit_onehot;
    logic [7:0]          font_nxt;
    logic [3:0]          nib;

    assign scan_tc    = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign frame_wrap = scan_tc && (digit_idx == DIG_W'(NUM_DIGITS - 1));

    always_comb begin
        digit_idx_nxt = digit_idx;
        if (scan_tc) begin
            digit_idx_nxt = (digit_idx == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end
    end

    // start resets high so the first cycle after release forces a conversion
    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            start     <= 1'b1;
        end else begin
            scan_cnt  <= scan_tc ? '0 : scan_cnt + 1'b1;
            digit_idx <= digit_idx_nxt;
            start     <= frame_wrap;
        end
    end

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            auto_cnt <= '0;
            rot_ch   <= '0;
        end else if (!i_auto) begin
            auto_cnt <= '0;
        end else if (auto_cnt == AUTO_W'(AUTO_DIV - 1)) begin
            auto_cnt <= '0;
            rot_ch   <= (rot_ch == CH_W'(NUM_CH - 1)) ? '0 : rot_ch + 1'b1;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    always_comb begin
        sel_ch = '0;
        if (i_auto) begin
            sel_ch = rot_ch;
        end else if ({1'b0, i_ch_sel} < NUM_CH_C) begin
            sel_ch = i_ch_sel;
        end
    end

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (sh_cnt == SH_W'(DATA_W - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NIB; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            conv_ch <= '0;
            bin     <= '0;
            bcd     <= '0;
            sh_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        conv_ch <= sel_ch;
                        bin     <= i_data[int'(sel_ch)*DATA_W +: DATA_W];
                    end
                end
                LOAD: begin
                    bcd    <= '0;
                    sh_cnt <= '0;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    sh_cnt     <= sh_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign commit   = (state == DONE);
    assign bcd_pad  = PAD_W'(bcd);
    assign conv_ovf = |(bcd_pad >> DISP_W);

    // Output registers are fed from next-state values so select and font
    // change on the same edge as the digit index and the display register.
    always_comb begin
        disp_nxt     = commit ? bcd_pad[DISP_W-1:0] : disp;
        valid_nxt    = valid | commit;
        ovf_nxt      = commit ? conv_ovf : o_ovf;
        digit_onehot = NUM_DIGITS'(1) << digit_idx_nxt;
        nib          = disp_nxt[int'(digit_idx_nxt)*4 +: 4];
`ifdef FND_LZB_EN
        blank = (digit_idx_nxt != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(digit_idx_nxt)) && (disp_nxt[j*4 +: 4] != 4'd0)) begin
                blank = 1'b0;
            end
        end
`else
        blank = 1'b0;
`endif
        sel_nxt  = '1;
        font_nxt = 8'hFF;
        if (valid_nxt) begin
            if (ovf_nxt) begin
                sel_nxt  = ~digit_onehot;
                font_nxt = 8'hBF;
            end else if (!blank) begin
                sel_nxt  = ~digit_onehot;
                font_nxt = seg_font(nib);
            end
        end
    end

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            disp        <= '0;
            valid       <= 1'b0;
            o_ovf       <= 1'b0;
            o_ch_active <= '0;
            o_fndSelect <= '1;
            o_fndFont   <= 8'hFF;
        end else begin
            disp        <= disp_nxt;
            valid       <= valid_nxt;
            o_ovf       <= ovf_nxt;
            o_fndSelect <= sel_nxt;
            o_fndFont   <= font_nxt;
            if (commit) begin
                o_ch_active <= conv_ch;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fnd_mux_scanner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fnd_mux_scanner: directed self-checking bench for fnd_mux_scanner.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_fnd_mux_scanner;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 14;
    localparam int NUM_DIGITS = 4;
    localparam int SCAN_DIV   = 4;
    localparam int AUTO_DIV   = 64;
    localparam int CH_W       = 2;

    logic                     sysclk  = 1'b0;
    logic                     i_rst_n = 1'b1;
    logic [NUM_CH*DATA_W-1:0] i_data  = '0;
    logic [CH_W-1:0]          i_ch_sel = '0;
    logic                     i_auto  = 1'b0;
    logic [NUM_DIGITS-1:0]    o_fndSelect;
    logic [7:0]               o_fndFont;
    logic [CH_W-1:0]          o_ch_active;
    logic                     o_ovf;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    fnd_mux_scanner #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .AUTO_DIV   (AUTO_DIV)
    ) dut (
        .sysclk      (sysclk),
        .i_rst_n     (i_rst_n),
        .i_data      (i_data),
        .i_ch_sel    (i_ch_sel),
        .i_auto      (i_auto),
        .o_fndSelect (o_fndSelect),
        .o_fndFont   (o_fndFont),
        .o_ch_active (o_ch_active),
        .o_ovf       (o_ovf)
    );

    always #5 sysclk = ~sysclk;

    // Rising edges since the last reset release
    always @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) ecnt <= 0;
        else          ecnt <= ecnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_digit(input string tag, input logic [3:0] sel, input logic [7:0] font);
        check_val({tag, "_sel"}, 32'(o_fndSelect), 32'(sel));
        check_val({tag, "_font"}, 32'(o_fndFont), 32'(font));
    endtask

    task automatic chk_reset(input string tag);
        check_val({tag, "_sel"}, 32'(o_fndSelect), 32'hF);
        check_val({tag, "_font"}, 32'(o_fndFont), 32'hFF);
        check_val({tag, "_ch"}, 32'(o_ch_active), 32'h0);
        check_val({tag, "_ovf"}, 32'(o_ovf), 32'h0);
    endtask

    task automatic run_to(input int k);
        int guard;
        guard = 0;
        while (ecnt < k && guard < 2000) begin
            @(posedge sysclk);
            #1;
            guard++;
        end
        if (ecnt != k) check_val("run_to", 32'(ecnt), 32'(k));
    endtask

    task automatic set_ch(input int k, input int v);
        i_data[k*DATA_W +: DATA_W] = DATA_W'(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_ch(0, 7);
        set_ch(1, 1234);
        set_ch(2, 16383);
        set_ch(3, 40);
        i_ch_sel = 2'd1;
        i_auto   = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 chk_reset("rst0");
        repeat (2) @(negedge sysclk);
        i_rst_n = 1'b1;

        // select changes during the first conversion must not leak in
        run_to(3);  i_ch_sel = 2'd2;
        run_to(16); chk_digit("pre_valid", 4'hF, 8'hFF);
        run_to(17); chk_digit("c1_d0", 4'b1110, 8'h99);
        check_val("c1_ch", 32'(o_ch_active), 32'd1);
        check_val("c1_ovf", 32'(o_ovf), 32'd0);
        run_to(20); chk_digit("c1_d1", 4'b1101, 8'hB0);
        run_to(24); chk_digit("c1_d2", 4'b1011, 8'hA4);
        run_to(28); chk_digit("c1_d3", 4'b0111, 8'hF9);
        run_to(40); i_ch_sel = 2'd0;
        run_to(45); i_ch_sel = 2'd2;
        run_to(48); chk_digit("c1_hold", 4'b1110, 8'h99);
        check_val("c1_hold_ch", 32'(o_ch_active), 32'd1);
        run_to(49); chk_digit("ovf_d0", 4'b1110, 8'hBF);
        check_val("ovf_ch", 32'(o_ch_active), 32'd2);
        check_val("ovf_flag", 32'(o_ovf), 32'd1);
        run_to(50); set_ch(2, 9999);
        run_to(52); chk_digit("ovf_d1", 4'b1101, 8'hBF);
        run_to(80); check_val("ovf_hold", 32'(o_ovf), 32'd1);
        run_to(81); check_val("ovf_clr", 32'(o_ovf), 32'd0);
        chk_digit("n9999_d0", 4'b1110, 8'h90);
        run_to(82); i_ch_sel = 2'd0;
        run_to(92); chk_digit("n9999_d3", 4'b0111, 8'h90);
        run_to(113); chk_digit("n7_d0", 4'b1110, 8'hF8);
        check_val("n7_ch", 32'(o_ch_active), 32'd0);
        run_to(114); set_ch(0, 0);
`ifdef FND_LZB_EN
        run_to(116); chk_digit("n7_d1", 4'hF, 8'hFF);
        run_to(124); chk_digit("n7_d3", 4'hF, 8'hFF);
        run_to(145); chk_digit("n0_d0", 4'b1110, 8'hC0);
        run_to(148); chk_digit("n0_d1", 4'hF, 8'hFF);
`else
        run_to(116); chk_digit("n7_d1", 4'b1101, 8'hC0);
        run_to(124); chk_digit("n7_d3", 4'b0111, 8'hC0);
        run_to(145); chk_digit("n0_d0", 4'b1110, 8'hC0);
        run_to(148); chk_digit("n0_d1", 4'b1101, 8'hC0);
`endif

        // asynchronous reset in the middle of a frame
        run_to(150);
        #3 i_rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        set_ch(0, 10);
        set_ch(1, 20);
        set_ch(2, 30);
        set_ch(3, 40);
        i_auto   = 1'b1;
        i_ch_sel = 2'd3;
        repeat (2) @(negedge sysclk);
        i_rst_n = 1'b1;

        run_to(17);  check_val("auto0_ch", 32'(o_ch_active), 32'd0);
        chk_digit("auto0_d0", 4'b1110, 8'hC0);
        run_to(80);  check_val("auto0_hold", 32'(o_ch_active), 32'd0);
        run_to(81);  check_val("auto1_ch", 32'(o_ch_active), 32'd1);
        run_to(84);  chk_digit("auto1_d1", 4'b1101, 8'hA4);
        run_to(145); check_val("auto2_ch", 32'(o_ch_active), 32'd2);
        run_to(148); chk_digit("auto2_d1", 4'b1101, 8'hB0);
        run_to(209); check_val("auto3_ch", 32'(o_ch_active), 32'd3);
        run_to(212); chk_digit("auto3_d1", 4'b1101, 8'h99);
        run_to(273); check_val("autow_ch", 32'(o_ch_active), 32'd0);
        run_to(276); chk_digit("autow_d1", 4'b1101, 8'hF9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
